// File: rtl/fetch_boot_unit_pkg.sv
// Shared definitions for the fetch/boot unit: top-level state encoding.
package fetch_boot_unit_pkg;

  typedef enum logic [1:0] {
    FB_BOOT  = 2'd0,
    FB_FETCH = 2'd1,
    FB_ERROR = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fetch_boot_unit_boot_sequencer.sv
// Boot stream sequencer: word counter, accept handshake and optional checksum.
// Checksum logic present only when FETCH_BOOT_CHECKSUM_EN is defined.
module boot_sequencer #(
`ifdef FETCH_BOOT_CHECKSUM_EN
  parameter int DATA_WIDTH = 32,
`endif
  parameter int BOOT_WORDS = 16,
  parameter int CNT_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active,
  input  logic             boot_valid,
`ifdef FETCH_BOOT_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] boot_data,
`endif
  output logic [CNT_W-1:0] boot_cnt,
  output logic             boot_done,
  output logic             boot_fail
);

  logic accept;

  assign accept    = active & boot_valid;
  assign boot_done = accept & (boot_cnt == CNT_W'(BOOT_WORDS - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      boot_cnt <= '0;
    end else if (accept) begin
      boot_cnt <= boot_done ? '0 : boot_cnt + CNT_W'(1);
    end
  end

`ifdef FETCH_BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  // The last word of the stream carries the expected sum of all earlier words.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sum <= '0;
    end else if (boot_done) begin
      sum <= '0;
    end else if (accept) begin
      sum <= sum + boot_data;
    end
  end

  assign boot_fail = boot_done & (sum != boot_data);
`else
  assign boot_fail = 1'b0;
`endif

endmodule

// File: rtl/fetch_boot_unit.sv
// Boot loader plus IF stage: copies the boot stream into imem, then fetches.
// Optional boot checksum enabled by defining FETCH_BOOT_CHECKSUM_EN.
module fetch_boot_unit
  import fetch_boot_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BOOT_WORDS = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] boot_data,
  input  logic                  boot_valid,
  output logic                  boot_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  imem_we,
  output logic                  imem_oe,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  booting,
  output logic                  boot_error,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0] if_pcpp
);

  localparam int CNT_W = (BOOT_WORDS > 2) ? $clog2(BOOT_WORDS) : 1;

  fb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_W-1:0]      boot_cnt;
  logic                  boot_done;
  logic                  boot_fail;

  boot_sequencer #(
`ifdef FETCH_BOOT_CHECKSUM_EN
    .DATA_WIDTH (DATA_WIDTH),
`endif
    .BOOT_WORDS (BOOT_WORDS),
    .CNT_W      (CNT_W)
  ) u_seq (
    .clock      (clock),
    .reset      (reset),
    .active     (state_q == FB_BOOT),
    .boot_valid (boot_valid),
`ifdef FETCH_BOOT_CHECKSUM_EN
    .boot_data  (boot_data),
`endif
    .boot_cnt   (boot_cnt),
    .boot_done  (boot_done),
    .boot_fail  (boot_fail)
  );

  always_ff @(posedge clock) begin
    if (!reset) state_q <= FB_BOOT;
    else        state_q <= state_d;
  end

  // Write enable is masked by reset so a word offered during reset is never stored.
  always_comb begin
    state_d    = state_q;
    booting    = 1'b0;
    boot_ready = 1'b0;
    imem_we    = 1'b0;
    imem_oe    = 1'b0;
    imem_addr  = pc;
    imem_wdata = '0;
    case (state_q)
      FB_BOOT: begin
        booting    = 1'b1;
        boot_ready = 1'b1;
        imem_we    = boot_valid & reset;
        imem_addr  = RESET_PC + ADDR_WIDTH'(boot_cnt);
        imem_wdata = boot_data;
        if (boot_done) state_d = boot_fail ? FB_ERROR : FB_FETCH;
      end
      FB_FETCH: begin
        imem_oe = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FETCH_BOOT_CHECKSUM_EN
  assign boot_error = (state_q == FB_ERROR);
`else
  assign boot_error = 1'b0;
`endif

  // Redirect beats stall; the IF/ID payload is kept on a flush, only valid drops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pcpp  <= '0;
    end else begin
      case (state_q)
        FB_FETCH: begin
          if (redirect) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_instr <= imem_rdata;
            if_pcpp  <= pc + ADDR_WIDTH'(PC_STEP);
            if_valid <= 1'b1;
            pc       <= pc + ADDR_WIDTH'(PC_STEP);
          end
        end
        default: begin
          pc       <= RESET_PC;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_boot_unit.sv
// Testbench for fetch_boot_unit: vector table on a 4-word boot instance plus
// hand sequences for PC wrap (4-bit address) and, with FETCH_BOOT_CHECKSUM_EN, the checksum.
module tb_fetch_boot_unit;

`ifdef FETCH_BOOT_CHECKSUM_EN
  localparam logic [31:0] W3 = 32'h21;
  localparam logic [31:0] X3 = 32'h66;
`else
  localparam logic [31:0] W3 = 32'hD;
  localparam logic [31:0] X3 = 32'h24;
`endif

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset = 1'b0, a_valid = 1'b0, a_stall = 1'b0, a_redir = 1'b0;
  logic [31:0] a_data = '0, a_rpc = '0;
  logic        a_ready, a_we, a_oe, a_booting, a_err, a_ifv;
  logic [31:0] a_addr, a_wdata, a_rdata, a_instr, a_pcpp;
  logic [31:0] mem [64];

  fetch_boot_unit #(.BOOT_WORDS(4)) dut_a (
    .clock(clock), .reset(a_reset), .boot_data(a_data), .boot_valid(a_valid),
    .boot_ready(a_ready), .imem_addr(a_addr), .imem_wdata(a_wdata), .imem_we(a_we),
    .imem_oe(a_oe), .imem_rdata(a_rdata), .stall(a_stall), .redirect(a_redir),
    .redirect_pc(a_rpc), .booting(a_booting), .boot_error(a_err), .if_valid(a_ifv),
    .if_instr(a_instr), .if_pcpp(a_pcpp));

  assign a_rdata = mem[a_addr[5:0]];
  always @(posedge clock) if (a_we) mem[a_addr[5:0]] <= a_wdata;

  logic        b_reset = 1'b0, b_valid = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_ready, b_we, b_oe, b_booting, b_err, b_ifv;
  logic [3:0]  b_addr, b_pcpp;
  logic [31:0] b_wdata, b_rdata, b_instr;
  logic [31:0] memb [16];

  fetch_boot_unit #(.ADDR_WIDTH(4), .BOOT_WORDS(2), .RESET_PC(4'hE)) dut_b (
    .clock(clock), .reset(b_reset), .boot_data(b_data), .boot_valid(b_valid),
    .boot_ready(b_ready), .imem_addr(b_addr), .imem_wdata(b_wdata), .imem_we(b_we),
    .imem_oe(b_oe), .imem_rdata(b_rdata), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(4'h0), .booting(b_booting), .boot_error(b_err), .if_valid(b_ifv),
    .if_instr(b_instr), .if_pcpp(b_pcpp));

  assign b_rdata = memb[b_addr];
  always @(posedge clock) if (b_we) memb[b_addr] <= b_wdata;

  typedef struct {
    logic        rst, valid;
    logic [31:0] data;
    logic        stall, redir;
    logic [31:0] rpc;
    logic        chk;
    logic        booting, ready, we, oe;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] instr, pcpp;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   abort_idx = -1;

  function automatic void addVec(logic rst, logic valid, logic [31:0] data, logic stall,
                                 logic redir, logic [31:0] rpc, logic chk, logic booting,
                                 logic ready, logic we, logic oe, logic [31:0] addr,
                                 logic ifv, logic [31:0] instr, logic [31:0] pcpp);
    vec_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.stall = stall; v.redir = redir;
    v.rpc = rpc; v.chk = chk; v.booting = booting; v.ready = ready; v.we = we;
    v.oe = oe; v.addr = addr; v.ifv = ifv; v.instr = instr; v.pcpp = pcpp;
    vq.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    a_reset = v.rst; a_valid = v.valid; a_data = v.data;
    a_stall = v.stall; a_redir = v.redir; a_rpc = v.rpc;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef FETCH_BOOT_CHECKSUM_EN
  task automatic bootA(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    @(negedge clock); a_reset = 1'b0; a_valid = 1'b0; a_stall = 1'b0; a_redir = 1'b0;
    @(negedge clock); a_reset = 1'b1; a_valid = 1'b1; a_data = w0;
    @(negedge clock); a_data = w1;
    @(negedge clock); a_data = w2;
    @(negedge clock); a_data = w3;
    @(negedge clock); a_valid = 1'b0; #1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 16; i++) memb[i] = 32'h200 + i;

    //     rst v  data      st rd rpc     chk bt rdy we oe addr     ifv instr     pcpp
    addVec(0, 0, 32'h0,    0, 0, 32'h0,  0,  0, 0, 0, 0, 32'h0,  0,  32'h0,    32'h0);
    addVec(0, 1, 32'h55,   0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'hA,    0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'hEE,   0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h1,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'hB,    0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h1,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'hEE,   0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h2,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'hC,    1, 1, 32'h9,  1,  1, 1, 1, 0, 32'h2,  0,  32'h0,    32'h0);
    addVec(1, 1, W3,       0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h3,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h1,  1,  32'hA,    32'h1);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h2,  1,  32'hB,    32'h2);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h3,  1,  32'hC,    32'h3);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h4,  1,  W3,       32'h4);
    addVec(1, 0, 32'h0,    1, 0, 32'h0,  1,  0, 0, 0, 1, 32'h5,  1,  32'h1004, 32'h5);
    addVec(1, 0, 32'h0,    1, 0, 32'h0,  1,  0, 0, 0, 1, 32'h5,  1,  32'h1004, 32'h5);
    addVec(1, 0, 32'h0,    1, 0, 32'h0,  1,  0, 0, 0, 1, 32'h5,  1,  32'h1004, 32'h5);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h5,  1,  32'h1004, 32'h5);
    addVec(1, 0, 32'h0,    1, 1, 32'h20, 1,  0, 0, 0, 1, 32'h6,  1,  32'h1005, 32'h6);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h20, 0,  32'h1005, 32'h6);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h21, 1,  32'h1020, 32'h21);
    addVec(0, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h22, 1,  32'h1021, 32'h22);
    addVec(1, 1, 32'h11,   0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'h12,   0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h1,  0,  32'h0,    32'h0);
    addVec(0, 1, 32'h13,   0, 0, 32'h0,  1,  1, 1, 0, 0, 32'h2,  0,  32'h0,    32'h0);
    abort_idx = vq.size();
    addVec(1, 1, 32'h21,   0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'h22,   0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h1,  0,  32'h0,    32'h0);
    addVec(1, 1, 32'h23,   0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h2,  0,  32'h0,    32'h0);
    addVec(1, 1, X3,       0, 0, 32'h0,  1,  1, 1, 1, 0, 32'h3,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h0,  0,  32'h0,    32'h0);
    addVec(1, 0, 32'h0,    0, 0, 32'h0,  1,  0, 0, 0, 1, 32'h1,  1,  32'h21,   32'h1);

    $display("[TB] applying %0d table vectors", vq.size());
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clock);
      applyStimulus(vq[i]);
      #1;
      if (vq[i].chk) begin
        checkOutput($sformatf("v%0d_booting", i), {31'b0, a_booting}, {31'b0, vq[i].booting});
        checkOutput($sformatf("v%0d_ready", i),   {31'b0, a_ready},   {31'b0, vq[i].ready});
        checkOutput($sformatf("v%0d_we", i),      {31'b0, a_we},      {31'b0, vq[i].we});
        checkOutput($sformatf("v%0d_oe", i),      {31'b0, a_oe},      {31'b0, vq[i].oe});
        checkOutput($sformatf("v%0d_addr", i),    a_addr,             vq[i].addr);
        checkOutput($sformatf("v%0d_if_valid", i), {31'b0, a_ifv},    {31'b0, vq[i].ifv});
        checkOutput($sformatf("v%0d_if_instr", i), a_instr,           vq[i].instr);
        checkOutput($sformatf("v%0d_if_pcpp", i),  a_pcpp,            vq[i].pcpp);
        checkOutput($sformatf("v%0d_boot_error", i), {31'b0, a_err},  32'h0);
        if (vq[i].we) checkOutput($sformatf("v%0d_wdata", i), a_wdata, vq[i].data);
      end
      if (i == abort_idx) checkOutput("abort_no_write_mem2", mem[2], 32'hC);
    end
    checkOutput("boot_mem1", mem[1], 32'h22);
    checkOutput("boot_mem3", mem[3], X3);

    // PC wrap on a 4-bit address instance booted at 0xE
    @(negedge clock); b_reset = 1'b0;
    @(negedge clock); b_reset = 1'b1; b_valid = 1'b1; b_data = 32'h5; #1;
    checkOutput("wrap_boot_addr0", {28'b0, b_addr}, 32'hE);
    checkOutput("wrap_boot_we0", {31'b0, b_we}, 32'h1);
    @(negedge clock); #1;
    checkOutput("wrap_boot_addr1", {28'b0, b_addr}, 32'hF);
    @(negedge clock); b_valid = 1'b0; #1;
    checkOutput("wrap_fetch_addr0", {28'b0, b_addr}, 32'hE);
    checkOutput("wrap_fetch_oe", {31'b0, b_oe}, 32'h1);
    @(negedge clock); #1;
    checkOutput("wrap_pcpp_f", {28'b0, b_pcpp}, 32'hF);
    checkOutput("wrap_addr_f", {28'b0, b_addr}, 32'hF);
    checkOutput("wrap_instr_e", b_instr, 32'h5);
    @(negedge clock); #1;
    checkOutput("wrap_pcpp_0", {28'b0, b_pcpp}, 32'h0);
    checkOutput("wrap_addr_0", {28'b0, b_addr}, 32'h0);
    checkOutput("wrap_valid", {31'b0, b_ifv}, 32'h1);
    checkOutput("wrap_boot_error", {31'b0, b_err}, 32'h0);

`ifdef FETCH_BOOT_CHECKSUM_EN
    bootA(32'h1, 32'h2, 32'h3, 32'h6);
    checkOutput("csum_ok_booting", {31'b0, a_booting}, 32'h0);
    checkOutput("csum_ok_oe", {31'b0, a_oe}, 32'h1);
    checkOutput("csum_ok_error", {31'b0, a_err}, 32'h0);
    bootA(32'h1, 32'h2, 32'h3, 32'h7);
    checkOutput("csum_bad_mem3", mem[3], 32'h7);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("csum_bad_error_%0d", k), {31'b0, a_err}, 32'h1);
      checkOutput($sformatf("csum_bad_ifv_%0d", k), {31'b0, a_ifv}, 32'h0);
      checkOutput($sformatf("csum_bad_booting_%0d", k), {31'b0, a_booting}, 32'h0);
      checkOutput($sformatf("csum_bad_strobes_%0d", k), {30'b0, a_oe, a_we}, 32'h0);
      @(negedge clock); #1;
    end
    a_reset = 1'b0;
    @(negedge clock); a_reset = 1'b1; #1;
    checkOutput("csum_reset_error", {31'b0, a_err}, 32'h0);
    checkOutput("csum_reset_booting", {31'b0, a_booting}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
